sdp_ram_pipe: RTL and testbench
===============================

// Module: sdp_ram_pipe
// PURPOSE
// Simple dual-port RAM with independent write and read ports on one clock.
// Writes use byte-lane strobes. Reads are synchronous and have a configurable
// pipelined latency, with a valid flag. A parameter selects read-during-write
// collision behaviour. Used as the generic buffer and regfile store in memory
// subsystems where a combinational-read RAM cannot meet timing.
// PARAMETERS
// WIDTH       32  data word width in bits; must be a multiple of STRB_WIDTH
// DEPTH       64  number of words; need not be a power of two
// STRB_WIDTH   8  bits per write-strobe lane
// RD_LATENCY   1  cycles from RD_EN to RD_VALID; legal range 1..4
// RDW_MODE     0  0 = read-first (old data), 1 = write-first (merged new data)
// _WEN_WIDTH      localparam WIDTH/STRB_WIDTH; _ADDR_WIDTH localparam $clog2(DEPTH)
// PORTS
// CLK       in   1            clock, rising edge
// RST_N     in   1            reset, asynchronous, active-low
// WR_EN     in   1            write request this cycle
// WR_ADDR   in   _ADDR_WIDTH  write word address
// WR_DATA   in   WIDTH        write data
// WR_STRB   in   _WEN_WIDTH   per-lane write enable; lane i = bits [STRB_WIDTH*(i+1)-1 : STRB_WIDTH*i]
// RD_EN     in   1            read request this cycle
// RD_ADDR   in   _ADDR_WIDTH  read word address
// RD_DATA   out  WIDTH        read data; meaningful only when RD_VALID=1
// RD_VALID  out  1            RD_DATA carries the result of a read issued RD_LATENCY cycles earlier
// BEHAVIOUR
// - Reset (RST_N=0, async): all valid-pipeline stages cleared, RD_VALID=0, RD_DATA=0,
//   all data-pipeline stages=0. Memory array is NOT reset; its contents are retained
//   across a reset.
// - Write: at posedge with WR_EN=1 and WR_ADDR<DEPTH, each lane i with WR_STRB[i]=1 is
//   updated from WR_DATA. Unstrobed lanes are unchanged. WR_EN=1 with WR_STRB=0 is a no-op.
// - Read: RD_EN=1 at edge N samples the word at RD_ADDR (stage 1). Data and valid then
//   shift one stage per cycle. RD_DATA/RD_VALID reflect stage RD_LATENCY. They are valid
//   from edge N+RD_LATENCY-1 onward, so they are sampled at edge N+RD_LATENCY.
//   RD_LATENCY=1 means the read is visible in the cycle after the request.
// - Pipeline is free-running with no stall. Back-to-back reads give one result per cycle,
//   in issue order. A stage with valid=0 still shifts, and RD_DATA holds the last valid
//   word until the next valid word arrives.
// - Out-of-range address (>=DEPTH): the write is dropped, and the read returns 0 with
//   RD_VALID still asserted.
// - Same-cycle read and write to the same address:
//   - RDW_MODE=0: returns the pre-write word.
//   - RDW_MODE=1: returns a merged word, with strobed lanes from WR_DATA and the other
//     lanes from the old word.
//   - The array is updated in both modes.
// - Reads to an address written in an earlier cycle always see the written data.
// - Reset mid-operation: in-flight reads are discarded, and no RD_VALID pulse appears
//   after reset release for reads issued before reset.
// - Elaboration error if WIDTH % STRB_WIDTH != 0 or RD_LATENCY is outside 1..4.
// TESTING
// 1. WIDTH=32,RD_LATENCY=1: write 0xDEADBEEF @3 strb=4'hF; read @3 next cycle -> RD_VALID
//    1 cycle later, RD_DATA=0xDEADBEEF.
// 2. Byte strobes: write 0x11223344 @5, then 0xAABBCCDD @5 strb=4'b0101; read @5 ->
//    0x11BB33DD.
// 3. RD_LATENCY=3: issue reads @0..@7 on consecutive cycles -> 8 consecutive RD_VALID
//    cycles starting 3 cycles after the first read, data in issue order, then RD_VALID=0.
// 4. Collision @9 (old 0x00000000, write 0xCAFEF00D strb=4'b0011): RDW_MODE=0 ->
//    0x00000000; RDW_MODE=1 -> 0x0000F00D; a later read returns 0x0000F00D in both modes.
// 5. RD_LATENCY=4: issue 2 reads, assert RST_N=0 for 1 cycle mid-flight -> RD_VALID and
//    RD_DATA go to 0 asynchronously, no stale pulse after release; re-read of an earlier
//    written address returns its pre-reset contents.
// 6. DEPTH=48: write @50 then read @50 -> RD_DATA=0 with RD_VALID=1; words 0..47 unchanged.

Source files
------------

// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: simple dual-port RAM, one clock, byte-lane write strobes,
// synchronous read with a 1..4 stage free-running read pipeline and valid flag.
// RDW_MODE picks old data (0) or merged new data (1) on a same-address collision.
module sdp_ram_pipe #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 64,
    parameter int STRB_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    localparam int WEN_WIDTH  = WIDTH / STRB_WIDTH,
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [WEN_WIDTH-1:0]  i_wr_strb,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_rd_valid
);

    // Illegal configurations stop elaboration.
    if ((WIDTH % STRB_WIDTH) != 0) begin : g_bad_width
        $error("sdp_ram_pipe: WIDTH must be a multiple of STRB_WIDTH");
    end
    if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_latency
        $error("sdp_ram_pipe: RD_LATENCY must be within 1..4");
    end

    // DEPTH widened by one bit so addresses up to 2**ADDR_WIDTH-1 compare cleanly.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];

    // Replace strobed lanes of an old word with the matching lanes of new data.
    function automatic logic [WIDTH-1:0] f_lane_merge(
        input logic [WIDTH-1:0]     old_word,
        input logic [WIDTH-1:0]     new_word,
        input logic [WEN_WIDTH-1:0] strb
    );
        logic [WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < WEN_WIDTH; i++) begin
            if (strb[i]) begin
                merged[i*STRB_WIDTH +: STRB_WIDTH] = new_word[i*STRB_WIDTH +: STRB_WIDTH];
            end else begin
                merged[i*STRB_WIDTH +: STRB_WIDTH] = old_word[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
        return merged;
    endfunction

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [WIDTH-1:0]      r_dat_pipe [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_vld_pipe;

    logic             w_wr_in_range;
    logic             w_rd_in_range;
    logic             w_collide;
    logic [WIDTH-1:0] w_mem_word;
    logic [WIDTH-1:0] w_rd_word;

    // Address range checks and same-address collision detect.
    always_comb begin
        w_wr_in_range = ({1'b0, i_wr_addr} < LP_DEPTH);
        w_rd_in_range = ({1'b0, i_rd_addr} < LP_DEPTH);
        w_collide     = i_wr_en && w_wr_in_range && (i_wr_addr == i_rd_addr);
    end

    // Stage-1 read word: array content (pre-write), optionally merged with the colliding write.
    always_comb begin
        w_mem_word = '0;
        w_rd_word  = '0;
        if (w_rd_in_range) begin
            w_mem_word = r_mem[i_rd_addr];
        end else begin
            w_mem_word = '0;
        end
        if ((RDW_MODE == 1) && w_collide) begin
            w_rd_word = f_lane_merge(w_mem_word, i_wr_data, i_wr_strb);
        end else begin
            w_rd_word = w_mem_word;
        end
    end

    // Array write: only strobed lanes of in-range addresses; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_addr] <= f_lane_merge(r_mem[i_wr_addr], i_wr_data, i_wr_strb);
        end
    end

    // Read pipeline: valid always shifts; data only advances with valid so the output holds the last result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_pipe <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_dat_pipe[k] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= i_rd_en;
            if (i_rd_en) begin
                r_dat_pipe[0] <= w_rd_word;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                if (r_vld_pipe[k-1]) begin
                    r_dat_pipe[k] <= r_dat_pipe[k-1];
                end
            end
        end
    end

    assign o_rd_data  = r_dat_pipe[RD_LATENCY-1];
    assign o_rd_valid = r_vld_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// tb_sdp_ram_pipe: three configurations of sdp_ram_pipe on one clock.
//   port 0: DEPTH=64, RD_LATENCY=1, read-first
//   port 1: DEPTH=64, RD_LATENCY=3, write-first
//   port 2: DEPTH=48, RD_LATENCY=4, read-first
// Every read pushes {due cycle, expected word} to its port's queue; a negedge
// checker pops on the due cycle and otherwise requires RD_VALID=0.
module tb_sdp_ram_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic        wr_en   [3];
    logic [5:0]  wr_addr [3];
    logic [31:0] wr_data [3];
    logic [3:0]  wr_strb [3];
    logic        rd_en   [3];
    logic [5:0]  rd_addr [3];
    logic [31:0] rd_data [3];
    logic        rd_valid[3];

    sdp_ram_pipe #(.WIDTH(32), .DEPTH(64), .STRB_WIDTH(8), .RD_LATENCY(1), .RDW_MODE(0)) u_p0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en[0]), .i_wr_addr(wr_addr[0]), .i_wr_data(wr_data[0]), .i_wr_strb(wr_strb[0]),
        .i_rd_en(rd_en[0]), .i_rd_addr(rd_addr[0]), .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0])
    );

    sdp_ram_pipe #(.WIDTH(32), .DEPTH(64), .STRB_WIDTH(8), .RD_LATENCY(3), .RDW_MODE(1)) u_p1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en[1]), .i_wr_addr(wr_addr[1]), .i_wr_data(wr_data[1]), .i_wr_strb(wr_strb[1]),
        .i_rd_en(rd_en[1]), .i_rd_addr(rd_addr[1]), .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1])
    );

    sdp_ram_pipe #(.WIDTH(32), .DEPTH(48), .STRB_WIDTH(8), .RD_LATENCY(4), .RDW_MODE(0)) u_p2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_en(wr_en[2]), .i_wr_addr(wr_addr[2]), .i_wr_data(wr_data[2]), .i_wr_strb(wr_strb[2]),
        .i_rd_en(rd_en[2]), .i_rd_addr(rd_addr[2]), .o_rd_data(rd_data[2]), .o_rd_valid(rd_valid[2])
    );

    function automatic int lat(input int id);
        case (id)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 + (32'(i) * 32'h0001_0001);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push(input int id, input logic [31:0] expv);
        exp_t e;
        e.due  = cyc + lat(id);
        e.data = expv;
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic chk_port(input int id);
        exp_t e;
        bit   has;
        has = 1'b0;
        case (id)
            0: if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); has = 1'b1; end
            1: if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); has = 1'b1; end
            default: if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); has = 1'b1; end
        endcase
        if (has) begin
            check($sformatf("p%0d_valid@%0d", id, cyc), {31'b0, rd_valid[id]}, 32'd1);
            check($sformatf("p%0d_data@%0d", id, cyc), rd_data[id], e.data);
        end else begin
            check($sformatf("p%0d_idle@%0d", id, cyc), {31'b0, rd_valid[id]}, 32'd0);
        end
    endtask

    // Scoreboard checker, away from the active edge.
    always @(negedge clk) begin
        for (int id = 0; id < 3; id++) chk_port(id);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input int id, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en[id] = 1'b1; wr_addr[id] = a; wr_data[id] = d; wr_strb[id] = s;
        tick();
        wr_en[id] = 1'b0; wr_strb[id] = 4'h0;
    endtask

    task automatic do_read(input int id, input logic [5:0] a, input logic [31:0] expv);
        rd_en[id] = 1'b1; rd_addr[id] = a;
        push(id, expv);
        tick();
        rd_en[id] = 1'b0;
    endtask

    task automatic do_both(input int id, input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] expv);
        wr_en[id] = 1'b1; wr_addr[id] = a; wr_data[id] = d; wr_strb[id] = s;
        rd_en[id] = 1'b1; rd_addr[id] = a;
        push(id, expv);
        tick();
        wr_en[id] = 1'b0; wr_strb[id] = 4'h0; rd_en[id] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en[i] = 1'b0; wr_addr[i] = 6'd0; wr_data[i] = 32'd0; wr_strb[i] = 4'h0;
            rd_en[i] = 1'b0; rd_addr[i] = 6'd0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid_p%0d", i), {31'b0, rd_valid[i]}, 32'd0);
            check($sformatf("rst_data_p%0d", i), rd_data[i], 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Port 0: basic write/read, no-op strobe, byte lanes, read-first collision
        do_write(0, 6'd3, 32'hDEAD_BEEF, 4'hF);
        do_read (0, 6'd3, 32'hDEAD_BEEF);
        do_write(0, 6'd3, 32'h0000_0000, 4'h0);
        do_read (0, 6'd3, 32'hDEAD_BEEF);
        do_write(0, 6'd5, 32'h1122_3344, 4'hF);
        do_write(0, 6'd5, 32'hAABB_CCDD, 4'b0101);
        do_read (0, 6'd5, 32'h11BB_33DD);
        do_write(0, 6'd9, 32'h0000_0000, 4'hF);
        do_both (0, 6'd9, 32'hCAFE_F00D, 4'b0011, 32'h0000_0000);
        do_read (0, 6'd9, 32'h0000_F00D);
        idle(3);
        check("p0_hold_last", rd_data[0], 32'h0000_F00D);

        // Port 1: back-to-back reads at latency 3, then write-first collision
        for (int i = 0; i < 8; i++) do_write(1, 6'(i), 32'h0B00_0000 + 32'(i) * 32'h11, 4'hF);
        for (int i = 0; i < 8; i++) do_read(1, 6'(i), 32'h0B00_0000 + 32'(i) * 32'h11);
        idle(5);
        do_write(1, 6'd9, 32'h0000_0000, 4'hF);
        do_both (1, 6'd9, 32'hCAFE_F00D, 4'b0011, 32'h0000_F00D);
        do_read (1, 6'd9, 32'h0000_F00D);
        idle(5);

        // Port 2: DEPTH=48, out-of-range write dropped and read returns 0 with valid
        for (int i = 0; i < 48; i++) do_write(2, 6'(i), pat(i), 4'hF);
        do_write(2, 6'd50, 32'hFFFF_FFFF, 4'hF);
        do_read (2, 6'd50, 32'h0000_0000);
        for (int i = 0; i < 48; i++) do_read(2, 6'(i), pat(i));
        idle(6);

        // Port 2: reset mid-flight discards pending reads, array keeps contents
        do_read(2, 6'd3, pat(3));
        idle(6);
        check("p2_pre_reset_data", rd_data[2], pat(3));
        do_read(2, 6'd4, pat(4));
        do_read(2, 6'd5, pat(5));
        tick();
        rst_n = 1'b0;
        q2.delete();
        #1;
        check("p2_async_rst_valid", {31'b0, rd_valid[2]}, 32'd0);
        check("p2_async_rst_data", rd_data[2], 32'd0);
        tick();
        rst_n = 1'b1;
        idle(8);
        do_read(2, 6'd3, pat(3));
        idle(6);

        check("drain_queues", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
